// File: rtl/press_counter_pkg.sv
// Shared types and helpers for the press event counter.
package press_counter_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        RELEASE,
        IDLE,
        EDGE,
        PRESSED
    } state_e;

    // Decimal increment across all digits; MSB of the result is the carry out of the top digit.
    function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        logic             c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                    c = 1'b1;
                end else begin
                    d = d + 4'd1;
                    c = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/press_event_counter_if.sv
// Button level in, press events and BCD count out.
interface press_event_counter_if;
    import press_counter_pkg::*;

    logic             db;
    logic             press_tick;
    logic             long_press;
    logic [BCD_W-1:0] count_bcd;
    logic             overflow;

    modport master (
        output db,
        input  press_tick,
        input  long_press,
        input  count_bcd,
        input  overflow
    );

    modport slave (
        input  db,
        output press_tick,
        output long_press,
        output count_bcd,
        output overflow
    );

endinterface

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter; max_tick is high for one cycle every M cycles.
module mod_m_counter #(
    parameter int unsigned M = 10
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam int unsigned W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] r_q;
    logic [W-1:0] r_d;

    // Next count: wrap to zero after the last value.
    always_comb begin
        r_d = (r_q == LAST) ? '0 : r_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign max_tick = (r_q == LAST);

endmodule

// File: rtl/press_event_counter.sv
// Counts short button presses in BCD; a long hold clears the count.
module press_event_counter
    import press_counter_pkg::*;
#(
    parameter int unsigned TICK_M     = 1_000_000,
    parameter int unsigned HOLD_TICKS = 200
) (
    input logic                  clk,
    input logic                  reset_n,
    press_event_counter_if.slave bus
);

    localparam int unsigned  HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [BCD_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             press_tick_q, press_tick_d;
    logic             long_q, long_d;
    logic [BCD_W:0]   inc;
    logic             m_tick;
    logic             tb_reset;

    assign tb_reset = ~reset_n;

    mod_m_counter #(
        .M(TICK_M)
    ) u_time_base (
        .clk      (clk),
        .reset    (tb_reset),
        .max_tick (m_tick)
    );

    assign inc = bcd_inc(count_q);

    // Next-state and output decode; press_tick is registered so it is high exactly while in EDGE.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        press_tick_d = 1'b0;
        long_d       = 1'b0;
        unique case (state_q)
            RELEASE: begin
                if (!bus.db) state_d = IDLE;
            end
            IDLE: begin
                if (bus.db) begin
                    state_d      = EDGE;
                    press_tick_d = 1'b1;
                end
            end
            EDGE: begin
                hold_d  = '0;
                count_d = inc[BCD_W-1:0];
                if (inc[BCD_W]) ovf_d = 1'b1;
                state_d = bus.db ? PRESSED : IDLE;
            end
            PRESSED: begin
                if (!bus.db) begin
                    state_d = IDLE;
                end else if (m_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        long_d  = 1'b1;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = RELEASE;
        endcase
    end

    // State, count and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RELEASE;
            hold_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            press_tick_q <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            press_tick_q <= press_tick_d;
            long_q       <= long_d;
        end
    end

    assign bus.press_tick = press_tick_q;
    assign bus.long_press = long_q;
    assign bus.count_bcd  = count_q;
    assign bus.overflow   = ovf_q;

endmodule
